// File: rtl/gcm_iv_builder_if.sv
// gcm_iv_builder_if: seed request, LFSR control and IV/J0 handshake bundle.
// The slave modport is the builder; the master modport is its environment.
interface gcm_iv_builder_if;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned IV_W   = 96;
   localparam int unsigned J0_W   = 128;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned REJ_W  = 16;

   logic              seed_valid;
   logic [WORD_W-1:0] seed;
   logic              seed_err;
   logic              rnd_go;
   logic [WORD_W-1:0] rnd_seed;
   logic [WORD_W-1:0] rnd_value;
   logic [IV_W-1:0]   iv;
   logic [J0_W-1:0]   j0;
   logic              iv_valid;
   logic              iv_ready;
   logic              exhausted;
   logic [CNT_W-1:0]  issued_count;
   logic [REJ_W-1:0]  reject_count;

   modport slave (
      input  seed_valid, seed, rnd_value, iv_ready,
      output seed_err, rnd_go, rnd_seed, iv, j0, iv_valid,
             exhausted, issued_count, reject_count
   );

   modport master (
      output seed_valid, seed, rnd_value, iv_ready,
      input  seed_err, rnd_go, rnd_seed, iv, j0, iv_valid,
             exhausted, issued_count, reject_count
   );
endinterface

// File: rtl/gcm_iv_builder.sv
// gcm_iv_builder: seeds and runs the 16-bit LFSR, packs six words into a 96-bit GCM IV,
// filters zero/repeated IVs and issues IV + J0 over valid/ready with a per-seed limit.
module gcm_iv_builder #(
   parameter logic [31:0] MAX_IVS = 32'hFFFF_FFFF
) (
   input  logic            clk,
   input  logic            rst_n,
   gcm_iv_builder_if.slave bus
);
   localparam int unsigned WORD_W    = 16;
   localparam int unsigned IV_W      = 96;
   localparam int unsigned CNT_W     = 32;
   localparam int unsigned REJ_W     = 16;
   localparam int unsigned WIDX_W    = 3;
   localparam int unsigned NUM_WORDS = 6;
   localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_UNSEEDED, S_RESTART, S_PRIME, S_FILL, S_CHECK, S_HOLD, S_EXHAUSTED
   } state_e;

   state_e              state_q, state_d;
   logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
   logic [IV_W-1:0]     buf_q, buf_d;
   logic [IV_W-1:0]     iv_q, iv_d;
   logic [IV_W-1:0]     prev_q, prev_d;
   logic                j0_lsb_q, j0_lsb_d;
   logic                iv_valid_q, iv_valid_d;
   logic                exhausted_q, exhausted_d;
   logic [CNT_W-1:0]    issued_q, issued_d;
   logic [REJ_W-1:0]    reject_q, reject_d;
   logic                seed_err_q, seed_err_d;
   logic                rnd_go_q, rnd_go_d;
   logic [WORD_W-1:0]   rnd_seed_q, rnd_seed_d;
   logic                pend_q, pend_d;
   logic [WORD_W-1:0]   pend_seed_q, pend_seed_d;

   logic                seed_ok_c;
   logic                accept_c;
   logic                cand_bad_c;
   logic [CNT_W-1:0]    issued_inc_c;

   assign seed_ok_c    = bus.seed_valid && (bus.seed != '0);
   assign accept_c     = iv_valid_q && bus.iv_ready;
   assign cand_bad_c   = (buf_q == '0) || (buf_q == prev_q);
   assign issued_inc_c = issued_q + CNT_W'(1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_UNSEEDED;
      else        state_q <= state_d;
   end

   // Next-state logic; a valid seed restarts from every state except HOLD
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_UNSEEDED, S_EXHAUSTED: if (seed_ok_c) state_d = S_RESTART;
         S_RESTART: state_d = seed_ok_c ? S_RESTART : S_PRIME;
         S_PRIME:   state_d = seed_ok_c ? S_RESTART : S_FILL;
         S_FILL: begin
            if (seed_ok_c)                    state_d = S_RESTART;
            else if (word_idx_q == LAST_IDX)  state_d = S_CHECK;
         end
         S_CHECK: begin
            if (seed_ok_c)       state_d = S_RESTART;
            else if (cand_bad_c) state_d = S_FILL;
            else                 state_d = S_HOLD;
         end
         S_HOLD: begin
            if (accept_c) begin
               if (seed_ok_c || pend_q)          state_d = S_RESTART;
               else if (issued_inc_c == MAX_IVS) state_d = S_EXHAUSTED;
               else                              state_d = S_FILL;
            end
         end
         default: state_d = S_UNSEEDED;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      word_idx_d  = word_idx_q;
      buf_d       = buf_q;
      iv_d        = iv_q;
      prev_d      = prev_q;
      j0_lsb_d    = j0_lsb_q;
      iv_valid_d  = iv_valid_q;
      exhausted_d = exhausted_q;
      issued_d    = issued_q;
      reject_d    = reject_q;
      rnd_seed_d  = rnd_seed_q;
      pend_d      = pend_q;
      pend_seed_d = pend_seed_q;
      seed_err_d  = bus.seed_valid && (bus.seed == '0);
      rnd_go_d    = !(state_d inside {S_UNSEEDED, S_RESTART, S_EXHAUSTED});

      if (seed_ok_c && (state_q != S_HOLD)) begin
         rnd_seed_d  = bus.seed;
         issued_d    = '0;
         exhausted_d = 1'b0;
         word_idx_d  = '0;
      end

      case (state_q)
         S_FILL: begin
            // Shift-in leaves the first captured word in the top 16 bits after six captures
            if (!seed_ok_c) begin
               buf_d      = {buf_q[IV_W-WORD_W-1:0], bus.rnd_value};
               word_idx_d = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + WIDX_W'(1);
            end
         end
         S_CHECK: begin
            if (!seed_ok_c) begin
               if (cand_bad_c) begin
                  if (reject_q != '1) reject_d = reject_q + REJ_W'(1);
               end else begin
                  prev_d     = buf_q;
                  iv_d       = buf_q;
                  j0_lsb_d   = 1'b1;
                  iv_valid_d = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (seed_ok_c) begin
               pend_d      = 1'b1;
               pend_seed_d = bus.seed;
            end
            // A pending seed takes effect on release and starts a fresh issue budget
            if (accept_c) begin
               iv_valid_d = 1'b0;
               word_idx_d = '0;
               if (seed_ok_c || pend_q) begin
                  rnd_seed_d  = seed_ok_c ? bus.seed : pend_seed_q;
                  issued_d    = '0;
                  exhausted_d = 1'b0;
                  pend_d      = 1'b0;
               end else begin
                  issued_d = issued_inc_c;
                  if (issued_inc_c == MAX_IVS) exhausted_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_idx_q  <= '0;
         buf_q       <= '0;
         iv_q        <= '0;
         prev_q      <= '0;
         j0_lsb_q    <= 1'b0;
         iv_valid_q  <= 1'b0;
         exhausted_q <= 1'b0;
         issued_q    <= '0;
         reject_q    <= '0;
         seed_err_q  <= 1'b0;
         rnd_go_q    <= 1'b0;
         rnd_seed_q  <= '0;
         pend_q      <= 1'b0;
         pend_seed_q <= '0;
      end else begin
         word_idx_q  <= word_idx_d;
         buf_q       <= buf_d;
         iv_q        <= iv_d;
         prev_q      <= prev_d;
         j0_lsb_q    <= j0_lsb_d;
         iv_valid_q  <= iv_valid_d;
         exhausted_q <= exhausted_d;
         issued_q    <= issued_d;
         reject_q    <= reject_d;
         seed_err_q  <= seed_err_d;
         rnd_go_q    <= rnd_go_d;
         rnd_seed_q  <= rnd_seed_d;
         pend_q      <= pend_d;
         pend_seed_q <= pend_seed_d;
      end
   end

   assign bus.seed_err     = seed_err_q;
   assign bus.rnd_go       = rnd_go_q;
   assign bus.rnd_seed     = rnd_seed_q;
   assign bus.iv           = iv_q;
   assign bus.j0           = {iv_q, 31'b0, j0_lsb_q};
   assign bus.iv_valid     = iv_valid_q;
   assign bus.exhausted    = exhausted_q;
   assign bus.issued_count = issued_q;
   assign bus.reject_count = reject_q;
endmodule
